// File: rtl/ram_burst_reader_pkg.sv
// Shared types and sizing for the RAM burst reader.
// Imported by the controller and its output buffer.
package ram_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/ram_burst_reader_if.sv
// Request, RAM and stream signals of the burst reader.
// master = reader side, slave = environment side.
interface ram_burst_reader_if #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
);

  logic              start;
  logic [AWIDTH-1:0] base_addr;
  logic [AWIDTH:0]   length;
  logic [AWIDTH-1:0] ram_addr;
  logic              ram_we;
  logic [DWIDTH-1:0] ram_dout;
  logic [DWIDTH-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, base_addr, length,
    input  ram_dout, out_ready,
    output ram_addr, ram_we,
    output out_data, out_valid,
    output busy, done
  );

  modport slave (
    output start, base_addr, length,
    output ram_dout, out_ready,
    input  ram_addr, ram_we,
    input  out_data, out_valid,
    input  busy, done
  );

endinterface

// File: rtl/ram_rd_skid_buf.sv
// Two-entry FIFO: output register plus skid slot.
// Head is only replaced on a pop or when empty.
module ram_rd_skid_buf
  import ram_burst_reader_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic [OCC_W-1:0]  count
);

  logic [DWIDTH-1:0] head_q;
  logic [DWIDTH-1:0] skid_q;
  logic [OCC_W-1:0]  cnt_q;
  logic              pop;
  logic              full;

  assign out_valid = cnt_q != '0;
  assign out_data  = head_q;
  assign count     = cnt_q;
  assign pop       = out_valid && out_ready;
  assign full      = cnt_q == OCC_W'(BUF_DEPTH);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else if (pop && full) begin
      head_q <= skid_q;
      if (in_valid) skid_q <= in_data;
      else cnt_q <= cnt_q - OCC_W'(1);
    end else if (pop) begin
      if (in_valid) head_q <= in_data;
      else cnt_q <= cnt_q - OCC_W'(1);
    end else if (in_valid) begin
      if (out_valid) skid_q <= in_data;
      else head_q <= in_data;
      cnt_q <= cnt_q + OCC_W'(1);
    end
  end

endmodule

// File: rtl/ram_burst_reader.sv
// Streams a burst of words from a sync-read RAM,
// with address generation and burst control.
module ram_burst_reader
  import ram_burst_reader_pkg::*;
#(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input logic                clock,
  input logic                reset,
  ram_burst_reader_if.master bus
);

  localparam int CW = AWIDTH + 1;

  state_e            state_q;
  state_e            state_d;
  logic [AWIDTH-1:0] nxt_addr_q;
  logic [AWIDTH-1:0] addr_q;
  logic [CW-1:0]     len_q;
  logic [CW-1:0]     iss_cnt_q;
  logic [CW-1:0]     xfr_cnt_q;
  logic              inflight_q;
  logic              done_q;
  logic              issue;
  logic              pop;
  logic              accept;
  logic              last_iss;
  logic              last_xfr;
  logic [OCC_W-1:0]  buf_cnt;
  logic [OCC_W-1:0]  occ;

  ram_rd_skid_buf #(
    .DWIDTH (DWIDTH)
  ) u_buf (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (inflight_q),
    .in_data   (bus.ram_dout),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data),
    .count     (buf_cnt)
  );

  assign pop      = bus.out_valid && bus.out_ready;
  assign accept   = (state_q == IDLE) && bus.start;
  // A word leaving on this edge frees its slot for a new read.
  assign occ      = buf_cnt + OCC_W'(inflight_q)
                  - OCC_W'(pop);
  assign last_iss = (iss_cnt_q + CW'(1)) == len_q;
  assign last_xfr = (xfr_cnt_q + CW'(1)) == len_q;

  assign bus.ram_addr = issue ? nxt_addr_q : addr_q;
  assign bus.ram_we   = 1'b0;
  assign bus.busy     = state_q != IDLE;
  assign bus.done     = done_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && bus.length != '0)
          state_d = RUN;
      end
      RUN: begin
        if (occ < OCC_W'(BUF_DEPTH)) begin
          issue = 1'b1;
          if (last_iss) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && last_xfr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nxt_addr_q <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      iss_cnt_q  <= '0;
      xfr_cnt_q  <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= issue;
      done_q     <= (state_q == DRAIN) && pop && last_xfr;
      if (accept) begin
        len_q      <= bus.length;
        nxt_addr_q <= bus.base_addr;
        iss_cnt_q  <= '0;
        xfr_cnt_q  <= '0;
        done_q     <= bus.length == '0;
      end
      if (issue) begin
        addr_q     <= nxt_addr_q;
        nxt_addr_q <= nxt_addr_q + AWIDTH'(1);
        iss_cnt_q  <= iss_cnt_q + CW'(1);
      end
      if (pop) xfr_cnt_q <= xfr_cnt_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed and randomized bursts against a queue-based
// model of the expected word stream and its timing.
module tb_ram_burst_reader;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] mem [8];

  always #5 clock = ~clock;

  ram_burst_reader_if #(.AWIDTH(3), .DWIDTH(32)) bus ();

  ram_burst_reader #(
    .AWIDTH (3),
    .DWIDTH (32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always @(posedge clock) bus.ram_dout <= mem[bus.ram_addr];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 3) == 1;
    return 1'($urandom_range(0, 1));
  endfunction

  // Sits on negedges; cycle c lies between edge c-1 and edge c,
  // where edge 0 accepts the start.
  task automatic run_burst(input logic [2:0] base,
                           input logic [3:0] len,
                           input int mode,
                           input bit inject);
    logic [31:0] exp_q [$];
    logic [31:0] prev_d;
    int first_v, first_x, last_x, nx, done_c, nvalid;
    bit prev_v, prev_r, busy_ok, done_busy, we_ok;
    for (int i = 0; i < int'(len); i++)
      exp_q.push_back(32'h11 * ((int'(base) + i) % 8));
    first_v = -1; first_x = -1; last_x = -1;
    nx = 0; done_c = -1; nvalid = 0;
    prev_v = 0; prev_r = 0; prev_d = '0;
    busy_ok = 1; done_busy = 0; we_ok = 1;
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.length    = len;
    bus.out_ready = ready_for(mode, 0);
    @(negedge clock);
    bus.start     = 1'b0;
    bus.base_addr = 3'($urandom);
    bus.length    = 4'($urandom);
    for (int c = 1; c <= 100 && done_c < 0; c++) begin
      bus.out_ready = ready_for(mode, c);
      if (inject) begin
        bus.start     = (c == 3);
        bus.base_addr = 3'd5;
        bus.length    = 4'd3;
      end
      if (prev_v && !prev_r) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_data", bus.out_data, prev_d);
      end
      if (bus.ram_we !== 1'b0) we_ok = 0;
      if (bus.out_valid) begin
        nvalid++;
        if (first_v < 0) first_v = c;
      end
      if (bus.done) begin
        done_c    = c;
        done_busy = bus.busy;
      end else if (bus.busy !== (len != 0)) begin
        busy_ok = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        check("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0)
          check("word", bus.out_data, exp_q.pop_front());
        nx++;
        if (first_x < 0) first_x = c;
        last_x = c;
      end
      prev_v = bus.out_valid;
      prev_r = bus.out_ready;
      prev_d = bus.out_data;
      @(negedge clock);
    end
    bus.start = 1'b0;
    check("done_seen", 32'(done_c >= 0), 32'd1);
    check("n_xfer", 32'(nx), 32'(len));
    check("words_left", 32'(exp_q.size()), 32'd0);
    check("busy_during", 32'(busy_ok), 32'd1);
    check("busy_at_done", 32'(done_busy), 32'd0);
    check("ram_we_low", 32'(we_ok), 32'd1);
    check("done_pulse_end", 32'(bus.done), 32'd0);
    check("idle_valid", 32'(bus.out_valid), 32'd0);
    if (len == 0) begin
      check("len0_done_cycle", 32'(done_c), 32'd1);
      check("len0_no_valid", 32'(nvalid), 32'd0);
    end else begin
      check("first_valid", 32'(first_v), 32'd3);
      check("done_after_last", 32'(done_c), 32'(last_x + 1));
      if (mode == 0)
        check("back_to_back", 32'(last_x - first_x), 32'(len - 1));
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 8; i++) mem[i] = 32'h11 * i;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.length    = '0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", bus.out_data, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_addr", 32'(bus.ram_addr), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    run_burst(3'd2, 4'd4, 0, 0);
    run_burst(3'd6, 4'd4, 0, 0);
    run_burst(3'd0, 4'd8, 1, 0);
    run_burst(3'd0, 4'd0, 0, 0);
    run_burst(3'd4, 4'd0, 2, 0);
    run_burst(3'd0, 4'd6, 0, 1);
    run_burst(3'd7, 4'd8, 2, 1);

    bus.start     = 1'b1;
    bus.base_addr = 3'd1;
    bus.length    = 4'd5;
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    n = 0;
    for (int k = 0; k < 20 && n < 2; k++) begin
      if (bus.out_valid && bus.out_ready) n++;
      @(negedge clock);
    end
    check("abort_xfers", 32'(n), 32'd2);
    reset = 1'b1;
    #1;
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_data", bus.out_data, 32'd0);
    check("abort_addr", 32'(bus.ram_addr), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("abort_no_done", 32'(bus.done), 32'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_done", 32'(bus.done), 32'd0);
    run_burst(3'd0, 4'd1, 0, 0);

    for (int r = 0; r < 8; r++)
      run_burst(3'($urandom_range(0, 7)),
                4'($urandom_range(0, 8)),
                int'($urandom_range(0, 2)), r[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
